freq_gate_ctrl: RTL and testbench
=================================

// Module: freq_gate_ctrl
// PURPOSE
//   Measurement sequencer for the frequency counter's cascaded BCD counter chain.
//   - Sequences each measurement: clears the chain, opens a fixed gate window, then latches the result.
//   - Synchronises the external input sig_in and forwards one count-enable pulse per rising edge, only while the gate is open.
//   - Detects overflow from the top digit's carry. Sits between the input pin and the bcd counter chain / display latch.
// PARAMETERS
//   GATE_CYCLES    100_000_000  gate window length in clk cycles (1 s at 100 MHz); legal range >= 4
//   GATE_W         27           gate down-counter width; must satisfy 2**GATE_W > GATE_CYCLES
//   SETTLE_CYCLES  2            post-gate settle cycles before latch, legal range 1..15
// PORTS
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-low reset (0 = reset)
//   start       in   1  one-shot request; sampled in IDLE only
//   continuous  in   1  1 = re-arm automatically after every latch
//   sig_in      in   1  asynchronous signal under measurement
//   top_carry   in   1  carry out of most-significant BCD digit
//   cnt_en      out  1  count pulse to digit 0, one clk wide per input edge
//   cnt_clr     out  1  synchronous clear to all digits, one clk wide
//   latch       out  1  load counter chain into display registers, one clk wide
//   overflow    out  1  sticky-per-measurement overflow, updated at latch
//   busy        out  1  high in every state except IDLE
//   done        out  1  one clk pulse, coincident with latch
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE; all outputs 0; synchroniser flops 0; gate counter 0.
//     Applies immediately, mid-measurement included; no latch is issued for the aborted run.
//   - FSM states IDLE, CLEAR, GATE, DRAIN, LATCH; encodings come from the shared header.
//   - IDLE: when start=1 or continuous=1 -> CLEAR.
//   - CLEAR: exactly 1 cycle. cnt_clr=1; gate counter <= GATE_CYCLES-1 (or selected range); ovf_acc <= 0. -> GATE.
//   - GATE: exactly GATE_CYCLES cycles. Counter decrements each cycle; at 0 -> DRAIN.
//   - DRAIN: exactly SETTLE_CYCLES cycles, cnt_en forced 0. -> LATCH.
//   - LATCH: 1 cycle. latch=1, done=1, overflow <= ovf_acc. Then -> CLEAR if continuous=1, else -> IDLE.
//   - Measurement period = GATE_CYCLES + SETTLE_CYCLES + 2 cycles.
//   - Input path: 2-FF synchroniser then prev flop; edge = s2 & ~prev.
//     cnt_en is registered: cnt_en <= edge & (state==GATE).
//     A sig_in rise reaches cnt_en at most 3 clk later. Edges whose edge term falls outside GATE are discarded.
//   - sig_in high and low phases must each be >= 2 clk; faster inputs are out of spec (edges may be lost).
//   - Overflow: ovf_acc sets when top_carry=1 in GATE or DRAIN; it never clears before the next CLEAR.
//   - start is ignored while busy=1 (no queueing).
//   - continuous dropped mid-run: current measurement completes and latches, then IDLE.
//   - start and continuous both high in IDLE: identical to continuous alone.
//   - cnt_clr, latch and cnt_en are never asserted in the same cycle.
// CONFIGURATION
//   Macro FREQ_RANGE_SEL_EN.
//   - Defined: adds input gate_sel[1:0], sampled in CLEAR. Gate length is GATE_CYCLES / 10**gate_sel
//     (values 0..3); the divided values are precomputed localparams. Adds output range_q[1:0], updated at latch.
//   - Undefined: no gate_sel/range_q ports; gate is always GATE_CYCLES.
// STRUCTURE
//   - Shared header freq_defs.vh: state encodings (FSM_IDLE..FSM_LATCH, 3 bits) and the decade divisor constants.
//     The display and bcd counter blocks include the same header.
//   - One sub-module, edge_sync: 2-FF synchroniser plus rising-edge detector with async active-low reset.
//     The FSM, gate counter and overflow logic stay in freq_gate_ctrl.
// TESTING (GATE_CYCLES=20, SETTLE_CYCLES=2, clk period 10 ns)
//   1. start pulse, sig_in free-running with period 4 clk (2 high/2 low)
//      -> cnt_clr 1 cycle after start; exactly 5 cnt_en pulses; latch/done once at 23 cycles after cnt_clr;
//         busy low the cycle after latch.
//   2. As test 1 with a 1-cycle top_carry during GATE -> overflow=1 after latch.
//      Repeat without top_carry -> overflow=0.
//   3. continuous=1 held -> latch pulses exactly 24 cycles apart. Drop continuous mid-GATE
//      -> that run still latches, then IDLE, busy=0.
//   4. start pulsed during GATE -> no extra cnt_clr; period and count unchanged.
//   5. reset=0 for 1 cycle mid-GATE -> all outputs 0 immediately, no latch.
//      After release with start -> normal run.
//   6. FREQ_RANGE_SEL_EN, GATE_CYCLES=100, gate_sel=1, sig_in period 4
//      -> gate 10 cycles; 2 or 3 cnt_en (phase-dependent, checked against model); range_q=1 at latch.

Source files
------------

// File: rtl/freq_gate_ctrl_pkg.sv
// freq_gate_ctrl_pkg: shared FSM encodings and decade divisors for the frequency counter blocks
// Contents:
//   FSM_IDLE..FSM_LATCH  3-bit measurement sequencer state encodings
//   DEC_DIV0..DEC_DIV3   decade divisors used for gate range selection (10**gate_sel)
package freq_gate_ctrl_pkg;
  localparam logic [2:0] FSM_IDLE  = 3'd0;
  localparam logic [2:0] FSM_CLEAR = 3'd1;
  localparam logic [2:0] FSM_GATE  = 3'd2;
  localparam logic [2:0] FSM_DRAIN = 3'd3;
  localparam logic [2:0] FSM_LATCH = 3'd4;
  localparam int DEC_DIV0 = 1;
  localparam int DEC_DIV1 = 10;
  localparam int DEC_DIV2 = 100;
  localparam int DEC_DIV3 = 1000;
endpackage

// File: rtl/freq_gate_ctrl_edge_sync.sv
// edge_sync: 2-FF synchroniser plus rising-edge detector for an asynchronous input
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_sig    asynchronous input
//   o_edge   one-cycle high on each synchronised rising edge (s2 & ~prev)
module edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);
  logic r_s1, r_s2, r_prev;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) {r_s1, r_s2, r_prev} <= '0;
    else {r_s1, r_s2, r_prev} <= {i_sig, r_s1, r_s2};
  assign o_edge = r_s2 & ~r_prev;
endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: measurement sequencer (clear, gate, drain, latch) for a cascaded BCD counter chain
// Optional feature macro: FREQ_RANGE_SEL_EN (adds i_gate_sel / o_range_q, gate = GATE_CYCLES / 10**gate_sel)
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       one-shot measurement request, sampled in IDLE only
//   i_continuous  re-arm automatically after every latch
//   i_sig_in      asynchronous signal under measurement
//   i_top_carry   carry out of the most-significant BCD digit
//   i_gate_sel    gate range select, sampled in CLEAR (FREQ_RANGE_SEL_EN only)
//   o_range_q     range of the last latched measurement (FREQ_RANGE_SEL_EN only)
//   o_cnt_en      count pulse to digit 0, one clk per input edge inside the gate
//   o_cnt_clr     synchronous clear to all digits, one clk
//   o_latch       load chain into display registers, one clk
//   o_overflow    overflow of the last latched measurement
//   o_busy        high in every state except IDLE
//   o_done        one clk pulse coincident with o_latch
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int GATE_CYCLES   = 100_000_000,
  parameter int GATE_W        = 27,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_continuous,
  input  logic       i_sig_in,
  input  logic       i_top_carry,
`ifdef FREQ_RANGE_SEL_EN
  input  logic [1:0] i_gate_sel,
  output logic [1:0] o_range_q,
`endif
  output logic       o_cnt_en,
  output logic       o_cnt_clr,
  output logic       o_latch,
  output logic       o_overflow,
  output logic       o_busy,
  output logic       o_done
);
  logic [2:0] r_state, w_next;
  logic [GATE_W-1:0] r_gate, w_load;
  logic [3:0] r_settle;
  logic r_ovf_acc, w_edge;
  edge_sync u_sync (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(i_sig_in), .o_edge(w_edge));
`ifdef FREQ_RANGE_SEL_EN
  localparam logic [GATE_W-1:0] LOAD0 = GATE_W'(GATE_CYCLES / DEC_DIV0 - 1);
  localparam logic [GATE_W-1:0] LOAD1 = GATE_W'(GATE_CYCLES / DEC_DIV1 - 1);
  localparam logic [GATE_W-1:0] LOAD2 = GATE_W'(GATE_CYCLES / DEC_DIV2 - 1);
  localparam logic [GATE_W-1:0] LOAD3 = GATE_W'(GATE_CYCLES / DEC_DIV3 - 1);
  logic [1:0] r_range;
  assign w_load = i_gate_sel == 2'd0 ? LOAD0 : i_gate_sel == 2'd1 ? LOAD1 :
                  i_gate_sel == 2'd2 ? LOAD2 : LOAD3;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_range   <= '0;
      o_range_q <= '0;
    end else begin
      if (r_state == FSM_CLEAR) r_range <= i_gate_sel;
      if (r_state == FSM_LATCH) o_range_q <= r_range;
    end
`else
  assign w_load = GATE_W'(GATE_CYCLES - 1);
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      FSM_IDLE:  if (i_start | i_continuous) w_next = FSM_CLEAR;
      FSM_CLEAR: w_next = FSM_GATE;
      FSM_GATE:  if (r_gate == '0) w_next = FSM_DRAIN;
      FSM_DRAIN: if (r_settle == '0) w_next = FSM_LATCH;
      FSM_LATCH: w_next = i_continuous ? FSM_CLEAR : FSM_IDLE;
      default:   w_next = FSM_IDLE;
    endcase
  end
  // r_settle is held at its reload value outside DRAIN so DRAIN always lasts SETTLE_CYCLES
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state    <= FSM_IDLE;
      r_gate     <= '0;
      r_settle   <= '0;
      r_ovf_acc  <= 1'b0;
      o_cnt_en   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      r_state  <= w_next;
      o_cnt_en <= w_edge & (r_state == FSM_GATE);
      r_settle <= r_state == FSM_DRAIN ? r_settle - 1'b1 : 4'(SETTLE_CYCLES - 1);
      if (r_state == FSM_CLEAR) r_gate <= w_load;
      else if (r_state == FSM_GATE && r_gate != '0) r_gate <= r_gate - 1'b1;
      if (r_state == FSM_CLEAR) r_ovf_acc <= 1'b0;
      else if ((r_state == FSM_GATE || r_state == FSM_DRAIN) && i_top_carry) r_ovf_acc <= 1'b1;
      if (r_state == FSM_LATCH) o_overflow <= r_ovf_acc;
    end
  assign o_cnt_clr = r_state == FSM_CLEAR;
  assign o_latch   = r_state == FSM_LATCH;
  assign o_done    = o_latch;
  assign o_busy    = r_state != FSM_IDLE;
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: directed scoreboard bench for freq_gate_ctrl (GATE_CYCLES=20, SETTLE_CYCLES=2)
module tb_freq_gate_ctrl;
  localparam int G = 20;
  localparam int S = 2;
  typedef struct packed {
    logic ovf;
    logic cont;
    logic gap;
    logic [1:0] rng;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, cont = 0, sig_in = 0, carry = 0;
  logic en0, clr0, lat0, ovf0, busy0, done0;
  logic m_en, m_clr, m_lat, m_ovf, m_busy, m_done;
  int checks = 0, failures = 0;
  int cyc = 0, clr_cyc = 0, last_lat = 0, en_cnt = 0, lat_total = 0, clr_total = 0, gcur = G, phase = 0;
  int rises[$];
  exp_t sbq[$];
  exp_t pend;
  bit pend_v = 0, sig_run = 0;
  always #5 clk = ~clk;
`ifdef FREQ_RANGE_SEL_EN
  logic [1:0] rng0, rng6, m_rng;
  logic start6 = 0, sel6 = 0;
  logic en6, clr6, lat6, ovf6, busy6, done6;
  freq_gate_ctrl #(.GATE_CYCLES(G), .GATE_W(8), .SETTLE_CYCLES(S)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_continuous(cont), .i_sig_in(sig_in),
    .i_top_carry(carry), .i_gate_sel(2'd0), .o_range_q(rng0), .o_cnt_en(en0), .o_cnt_clr(clr0),
    .o_latch(lat0), .o_overflow(ovf0), .o_busy(busy0), .o_done(done0));
  freq_gate_ctrl #(.GATE_CYCLES(100), .GATE_W(8), .SETTLE_CYCLES(S)) u6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start6), .i_continuous(1'b0), .i_sig_in(sig_in),
    .i_top_carry(1'b0), .i_gate_sel(2'd1), .o_range_q(rng6), .o_cnt_en(en6), .o_cnt_clr(clr6),
    .o_latch(lat6), .o_overflow(ovf6), .o_busy(busy6), .o_done(done6));
  assign {m_en, m_clr, m_lat, m_ovf, m_busy, m_done, m_rng} = sel6 ?
    {en6, clr6, lat6, ovf6, busy6, done6, rng6} : {en0, clr0, lat0, ovf0, busy0, done0, rng0};
`else
  freq_gate_ctrl #(.GATE_CYCLES(G), .GATE_W(8), .SETTLE_CYCLES(S)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_continuous(cont), .i_sig_in(sig_in),
    .i_top_carry(carry), .o_cnt_en(en0), .o_cnt_clr(clr0),
    .o_latch(lat0), .o_overflow(ovf0), .o_busy(busy0), .o_done(done0));
  assign {m_en, m_clr, m_lat, m_ovf, m_busy, m_done} = {en0, clr0, lat0, ovf0, busy0, done0};
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic push(input logic ovf, input logic c, input logic gap, input logic [1:0] rng);
    exp_t e;
    e.ovf = ovf;
    e.cont = c;
    e.gap = gap;
    e.rng = rng;
    sbq.push_back(e);
  endtask
  // One clock: sample outputs 1 ns after the edge, score them, then drive sig_in for the next cycle.
  // A sig_in rise driven in cycle k produces the edge term in cycle k+2, so it is counted when
  // k+2 lies in the gate cycles clr+1 .. clr+gate.
  task automatic tick();
    int n;
    logic nv;
    @(posedge clk);
    #1;
    cyc++;
    chk("exclusive_pulses", {31'd0, (m_clr & m_lat) | (m_en & (m_clr | m_lat))}, 32'd0);
    chk("done_eq_latch", {31'd0, m_done}, {31'd0, m_lat});
    if (pend_v) begin
      pend_v = 0;
      chk("overflow", {31'd0, m_ovf}, {31'd0, pend.ovf});
      chk("busy_after_latch", {31'd0, m_busy}, {31'd0, pend.cont});
`ifdef FREQ_RANGE_SEL_EN
      chk("range_q", {30'd0, m_rng}, {30'd0, pend.rng});
`endif
    end
    if (m_en) en_cnt++;
    if (m_clr) begin
      clr_total++;
      clr_cyc = cyc;
      en_cnt = 0;
      while (rises.size() > 0 && rises[0] < cyc - 1) void'(rises.pop_front());
    end
    if (m_lat) begin
      lat_total++;
      chk("scoreboard_nonempty", {31'd0, sbq.size() > 0}, 32'd1);
      if (sbq.size() > 0) begin
        pend = sbq.pop_front();
        pend_v = 1;
        n = 0;
        foreach (rises[i]) if (rises[i] >= clr_cyc - 1 && rises[i] <= clr_cyc + gcur - 2) n++;
        chk("latch_offset", cyc - clr_cyc, gcur + S + 1);
        chk("cnt_en_count", en_cnt, n);
        if (pend.gap) chk("latch_period", cyc - last_lat, G + S + 2);
      end
      last_lat = cyc;
    end
    if (sig_run) begin
      phase = (phase + 1) % 4;
      nv = phase < 2;
      if (nv && !sig_in) rises.push_back(cyc);
      sig_in = nv;
    end
  endtask
  task automatic wait_lat(input int budget);
    int t, k;
    t = lat_total;
    k = 0;
    while (lat_total == t && k < budget) begin
      tick();
      k++;
    end
    chk("latch_timeout", {31'd0, lat_total != t}, 32'd1);
  endtask
  task automatic pulse_start();
    int st;
    st = cyc;
    start = 1;
    tick();
    start = 0;
    chk("clr_after_start", clr_cyc, st + 1);
  endtask
  initial begin
    int c0, l0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, en0, clr0, lat0, ovf0, busy0, done0}, 32'd0);
    rst_n = 1;
    sig_run = 1;
    repeat (5) tick();
    push(0, 0, 0, 0);
    pulse_start();
    wait_lat(60);
    tick();
    push(1, 0, 0, 0);
    pulse_start();
    repeat (8) tick();
    carry = 1;
    tick();
    carry = 0;
    wait_lat(60);
    tick();
    push(0, 0, 0, 0);
    pulse_start();
    wait_lat(60);
    tick();
    cont = 1;
    push(0, 1, 0, 0);
    push(0, 1, 1, 0);
    push(0, 0, 1, 0);
    wait_lat(60);
    wait_lat(60);
    repeat (10) tick();
    cont = 0;
    wait_lat(60);
    repeat (4) tick();
    chk("idle_after_continuous", {31'd0, m_busy}, 32'd0);
    c0 = clr_total;
    push(0, 0, 0, 0);
    pulse_start();
    repeat (6) tick();
    start = 1;
    tick();
    start = 0;
    wait_lat(60);
    tick();
    chk("no_extra_clr", clr_total - c0, 1);
    push(0, 0, 0, 0);
    pulse_start();
    repeat (8) tick();
    rst_n = 0;
    #1;
    chk("abort_outputs", {26'd0, en0, clr0, lat0, ovf0, busy0, done0}, 32'd0);
    tick();
    rst_n = 1;
    sbq.delete();
    l0 = lat_total;
    repeat (40) tick();
    chk("no_latch_after_abort", lat_total - l0, 0);
    push(0, 0, 0, 0);
    pulse_start();
    wait_lat(60);
    tick();
`ifdef FREQ_RANGE_SEL_EN
    repeat (3) tick();
    sel6 = 1;
    gcur = 10;
    push(0, 0, 0, 2'd1);
    start6 = 1;
    tick();
    start6 = 0;
    wait_lat(200);
    tick();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
